// File: rtl/reg_scan_reader.sv
// -----------------------------------------------------------------------------
// reg_scan_reader
//
// A bank of 2**ADDR_WIDTH general-purpose registers. It has one write port and
// one registered random-read port. A scan engine can take a snapshot of the
// whole bank and stream it out in index order over a valid/ready handshake.
// Writes to the live bank during a scan never disturb the words being streamed.
//
// Ports
//   clk        system clock; all state updates on the rising edge
//   reset      synchronous, active-high reset (wins over every other input)
//   wr_en      write strobe; bank[wr_addr] <= wr_data
//   wr_addr    write index
//   wr_data    write data
//   rd_addr    random-read index
//   rd_data    bank[rd_addr], registered (1-cycle latency, old value on collision)
//   start      scan request, honoured only while idle
//   busy       scan in progress (SEND or DONE)
//   out_valid  stream word valid
//   out_ready  consumer accepts the word
//   out_data   snapshot word at out_idx
//   out_idx    index of out_data
//   done       one-cycle pulse after the last word is accepted
// -----------------------------------------------------------------------------
module reg_scan_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_idx,
  output logic                  done
);

  localparam int N = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] bank_q [N];
  logic [DATA_WIDTH-1:0] snap_q [N];
  logic [DATA_WIDTH-1:0] rd_data_q;
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic                  snap_load;

  // ---------------------------------------------------------------------------
  // Register bank and read port
  // ---------------------------------------------------------------------------
  // NOTE: The bank is reset explicitly because the register contents must read
  // as zero after reset. This is a register file, not a RAM macro, so the reset
  // costs nothing special.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) bank_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      // NOTE: Non-blocking assignments make rd_data sample the pre-write
      // contents when wr_addr == rd_addr in the same cycle.
      if (wr_en) bank_q[wr_addr] <= wr_data;
      rd_data_q <= bank_q[rd_addr];
    end
  end

  // The snapshot copies the bank as it stood before any same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) snap_q[i] <= '0;
    end else if (snap_load) begin
      snap_q <= bank_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // NOTE: Every signal driven here gets a default first. Without that, a
  // missing branch would infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_load = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_load = 1'b1;
          idx_d     = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          // Terminal compare stops the counter at N-1, so it never wraps.
          if (idx_q == LAST_IDX) state_d = DONE;
          else                   idx_d   = idx_q + ADDR_WIDTH'(1);
        end
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign rd_data  = rd_data_q;
  // The snapshot and index are both zero after reset, so these outputs are
  // zero then too. They hold steady while out_ready is low.
  assign out_data = snap_q[idx_q];
  assign out_idx  = idx_q;

endmodule

// File: tb/tb_reg_scan_reader.sv
module tb_reg_scan_reader;

  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          start;
  logic          busy;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_idx;
  logic          done;

  int n_total = 0;
  int n_pass  = 0;

  reg_scan_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .start     (start),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge. Outputs are then sampled 1ns after the edge, and
  // new inputs are driven at the same point for the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Check every stream-side output in one call.
  task automatic check_stream(input string tag, input logic v, input logic b,
                              input logic d, input logic [AW-1:0] idx,
                              input logic [DW-1:0] data);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".busy"},      32'(busy),      32'(b));
    check({tag, ".done"},      32'(done),      32'(d));
    if (v) begin
      check({tag, ".out_idx"},  32'(out_idx),  32'(idx));
      check({tag, ".out_data"}, 32'(out_data), 32'(data));
    end
  endtask

  initial begin
    logic [DW-1:0] init_vals [4];
    init_vals[0] = 8'h11; init_vals[1] = 8'h22; init_vals[2] = 8'h33; init_vals[3] = 8'h44;

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr = '0; start = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;

    // --- Reset then idle: every address reads zero, stream quiet ---------
    for (int a = 0; a < 4; a++) begin
      rd_addr = AW'(a);
      step();
      check($sformatf("reset.rd%0d", a), 32'(rd_data), 32'h0);
      check_stream("reset.idle", 1'b0, 1'b0, 1'b0, '0, '0);
    end
    check("reset.out_data", 32'(out_data), 32'h0);
    check("reset.out_idx",  32'(out_idx),  32'h0);

    // --- Write/read ---------------------------------------------------------
    for (int a = 0; a < 4; a++) begin
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = init_vals[a];
      step();
    end
    wr_en = 1'b0; rd_addr = 2'd2;
    step();
    check("rd.addr2", 32'(rd_data), 32'h33);
    // Read and write hit the same address in one cycle: the old value returns.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h55; rd_addr = 2'd1;
    step();
    check("rd.collide_old", 32'(rd_data), 32'h22);
    wr_en = 1'b0;
    step();
    check("rd.collide_new", 32'(rd_data), 32'h55);
    // Put 0x22 back at address 1.
    wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h22;
    step();
    wr_en = 1'b0;

    // --- Full-rate scan -----------------------------------------------------
    out_ready = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_stream($sformatf("full.w%0d", i), 1'b1, 1'b1, 1'b0, AW'(i), init_vals[i]);
      step();
    end
    check_stream("full.done", 1'b0, 1'b1, 1'b1, '0, '0);
    step();
    check_stream("full.after", 1'b0, 1'b0, 1'b0, '0, '0);

    // --- Backpressure on index 1 --------------------------------------------
    start = 1'b1;
    step();
    start = 1'b0;
    check_stream("bp.w0", 1'b1, 1'b1, 1'b0, 2'd0, 8'h11);
    step();
    out_ready = 1'b0;
    check_stream("bp.w1", 1'b1, 1'b1, 1'b0, 2'd1, 8'h22);
    for (int k = 0; k < 3; k++) begin
      step();
      check_stream($sformatf("bp.hold%0d", k), 1'b1, 1'b1, 1'b0, 2'd1, 8'h22);
    end
    out_ready = 1'b1;
    step();
    check_stream("bp.w2", 1'b1, 1'b1, 1'b0, 2'd2, 8'h33);
    step();
    check_stream("bp.w3", 1'b1, 1'b1, 1'b0, 2'd3, 8'h44);
    step();
    check_stream("bp.done", 1'b0, 1'b1, 1'b1, '0, '0);
    step();
    check_stream("bp.after", 1'b0, 1'b0, 1'b0, '0, '0);

    // --- Snapshot isolation, plus a start pulse during SEND that is ignored ---
    start = 1'b1;
    step();
    start = 1'b0;
    check_stream("iso.w0", 1'b1, 1'b1, 1'b0, 2'd0, 8'h11);
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 8'hAA; start = 1'b1;
    step();
    wr_en = 1'b0; start = 1'b0;
    check_stream("iso.w1", 1'b1, 1'b1, 1'b0, 2'd1, 8'h22);
    step();
    check_stream("iso.w2", 1'b1, 1'b1, 1'b0, 2'd2, 8'h33);
    step();
    check_stream("iso.w3", 1'b1, 1'b1, 1'b0, 2'd3, 8'h44);
    step();
    check_stream("iso.done", 1'b0, 1'b1, 1'b1, '0, '0);
    step();
    check_stream("iso.after", 1'b0, 1'b0, 1'b0, '0, '0);
    rd_addr = 2'd3;
    step();
    check_stream("iso.no_rescan", 1'b0, 1'b0, 1'b0, '0, '0);
    check("iso.rd3_live", 32'(rd_data), 32'hAA);

    // --- Reset in the middle of a scan ----------------------------------------
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check_stream("mid.w2", 1'b1, 1'b1, 1'b0, 2'd2, 8'h33);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_stream("mid.abort", 1'b0, 1'b0, 1'b0, '0, '0);
    check("mid.out_idx", 32'(out_idx), 32'h0);
    for (int a = 0; a < 4; a++) begin
      rd_addr = AW'(a);
      step();
      check($sformatf("mid.rd%0d", a), 32'(rd_data), 32'h0);
      check_stream("mid.nodone", 1'b0, 1'b0, 1'b0, '0, '0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_stream($sformatf("zero.w%0d", i), 1'b1, 1'b1, 1'b0, AW'(i), 8'h00);
      step();
    end
    check_stream("zero.done", 1'b0, 1'b1, 1'b1, '0, '0);
    step();
    check_stream("zero.after", 1'b0, 1'b0, 1'b0, '0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_scan_reader.md
Name: reg_scan_reader

Overview:
- Bank of 2**ADDR_WIDTH general-purpose registers with one write port and one synchronous random-read port.
- A scan engine snapshots the whole bank on request and streams the words out in index order over a valid/ready handshake.
- Sits between control logic that writes setup/status words and a consumer that reads them back, such as a UART transmitter or debug dumper.
- All registers use synchronous reset.

Parameters:
- DATA_WIDTH, 8, width of each register and of every data port.
- ADDR_WIDTH, 2, register index width; bank depth N = 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_WIDTH  write index.
- wr_data  input  DATA_WIDTH  write data.
- rd_addr  input  ADDR_WIDTH  random-read index.
- rd_data  output  DATA_WIDTH  registered read data, one cycle after rd_addr.
- start  input  1  scan request; sampled only in IDLE.
- busy  output  1  high while a scan is in progress (SEND or DONE).
- out_valid  output  1  stream word valid.
- out_ready  input  1  consumer accepts the word.
- out_data  output  DATA_WIDTH  snapshot word.
- out_idx  output  ADDR_WIDTH  index of out_data.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (synchronous, active-high; wins over every other input in the same cycle):
  - all bank registers, snapshot registers and rd_data go to 0;
  - state goes to IDLE and the index counter to 0;
  - busy, out_valid, done, out_data and out_idx go to 0.
  - Reset asserted mid-scan aborts the scan: no done pulse, and out_valid is low on the next cycle.
- Write port:
  - when wr_en=1, bank[wr_addr] <= wr_data at the clock edge, so the new value is visible the following cycle.
  - Writes are accepted in every state, including during a scan.
- Read port:
  - rd_data <= bank[rd_addr] every cycle, giving 1-cycle latency.
  - If the write and read addresses collide in the same cycle, rd_data returns the old (pre-write) value.
- FSM states are IDLE, SEND and DONE.
  - IDLE: busy=0, out_valid=0. On start=1, snapshot[i] <= bank[i] for all i, taking the pre-write values if wr_en is active in the same cycle. The index counter goes to 0 and the state to SEND.
  - SEND: busy=1, out_valid=1, out_data=snapshot[idx], out_idx=idx.
    - On out_valid && out_ready: if idx == N-1, go to DONE; otherwise idx <= idx+1.
    - With out_ready low, out_data and out_idx hold stable and out_valid stays high (no retraction).
    - Back-to-back acceptance (ready held high) gives one word per cycle, so the full scan takes N cycles in SEND.
  - DONE: done=1 for exactly one cycle, busy=1, out_valid=0. Next state is IDLE and idx returns to 0.
- start is ignored in SEND and DONE and is not queued. A new scan can begin in the cycle after returning to IDLE.
- Writes during a scan change only the live bank; streamed data always equals the snapshot.
- The index counter is ADDR_WIDTH bits; terminal detection uses idx == N-1, so there is no wrap past N-1.
- Latency from start to first out_valid is 1 cycle. Minimum start-to-done interval is N+1 cycles.

Test Plan:
- Reset then idle: after reset, hold 3 cycles → rd_data=0 for all addresses, busy=0, out_valid=0, done=0.
- Write/read, N=4: write 0x11,0x22,0x33,0x44 to addr 0..3, then read addr 2 → rd_data=0x33 one cycle later. Same-cycle write 0x55 and read of addr 1 → old 0x22, then 0x55 on the next read.
- Full-rate scan: bank=0x11..0x44, pulse start with out_ready=1 → out_idx 0,1,2,3 with data 0x11,0x22,0x33,0x44 on 4 consecutive cycles, done pulse on the 5th cycle, then busy=0.
- Backpressure: scan with out_ready low for 3 cycles on idx 1 → out_data=0x22 and out_idx=1 held stable with out_valid=1; the stream resumes in order and done fires once.
- Snapshot isolation: start scan, then write 0xAA to addr 3 during SEND → streamed word 3 is 0x44, and a later rd_addr=3 returns 0xAA. A start pulse during SEND is ignored, giving exactly one done.
- Reset mid-scan: assert reset while idx=2 → next cycle out_valid=0, busy=0, no done, bank cleared to 0. A subsequent scan streams all zeros.
